// File: rtl/dll_div_pkg.sv
// ---------------------------------------------------------------------------
// dll_div_pkg
// Shared definitions for the multi-cycle restoring divider (dll_seq_divider).
//   - div_state_e : two-state control FSM encoding (IDLE, RUN)
//   - calc_iter   : iterations needed for a numerator width at a given radix
//   - cnt_width   : width of the iteration counter for a given ITER
//   - DIV_ALL_ONES / DIV_ONE / DIV_ZERO : wide result constants, sliced by
//     the user to the result width
// ---------------------------------------------------------------------------
package dll_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

    localparam logic [63:0] DIV_ALL_ONES = '1;
    localparam logic [63:0] DIV_ONE      = 64'd1;
    localparam logic [63:0] DIV_ZERO     = '0;

    // ceil(num_width / bits_per_cycle)
    function automatic int calc_iter(input int num_width, input int bits_per_cycle);
        return (num_width + bits_per_cycle - 1) / bits_per_cycle;
    endfunction

    // Counter must hold ITER-1; keep at least one bit for the ITER=1 case.
    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/dll_div_step.sv
// ---------------------------------------------------------------------------
// dll_div_step
// One combinational restoring-division step.
// Ports:
//   rem_i     : partial remainder entering the step (always < denom_i)
//   num_bit_i : next numerator bit, shifted into the remainder LSB
//   denom_i   : divisor magnitude
//   rem_o     : partial remainder leaving the step
//   q_bit_o   : resolved quotient bit (1 = subtraction kept)
// ---------------------------------------------------------------------------
module dll_div_step #(
    parameter int DEN_WIDTH = 9
) (
    input  logic [DEN_WIDTH-1:0] rem_i,
    input  logic                 num_bit_i,
    input  logic [DEN_WIDTH-1:0] denom_i,
    output logic [DEN_WIDTH-1:0] rem_o,
    output logic                 q_bit_o
);

    logic [DEN_WIDTH:0]   shifted;
    logic [DEN_WIDTH+1:0] diff;
    logic                 unused_diff_bit;

    assign shifted = {rem_i, num_bit_i};
    // One extra bit beyond the shifted value carries the borrow.
    assign diff    = {1'b0, shifted} - {2'b00, denom_i};
    assign q_bit_o = ~diff[DEN_WIDTH+1];

    // shifted < 2*denom, so a kept difference always fits in DEN_WIDTH bits;
    // diff[DEN_WIDTH] is therefore zero whenever it is selected.
    assign rem_o           = q_bit_o ? diff[DEN_WIDTH-1:0] : shifted[DEN_WIDTH-1:0];
    assign unused_diff_bit = diff[DEN_WIDTH];

endmodule

// File: rtl/dll_seq_divider.sv
// ---------------------------------------------------------------------------
// dll_seq_divider
// Multi-cycle restoring divider with start/ready/done handshake. Resolves
// BITS_PER_CYCLE quotient bits per clock; ITER = ceil(NUM_WIDTH/BITS_PER_CYCLE).
// Optional signed operation is enabled by defining DLL_SEQ_DIVIDER_SIGNED_EN.
// Ports:
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   start       : operation request, accepted only while ready=1
//   numer       : dividend, sampled on the accepting edge
//   denom       : divisor, sampled on the accepting edge
//   ready       : idle, can accept start
//   quotient    : registered quotient, held until the next completion
//   remain      : registered remainder, held until the next completion
//   done        : one-cycle completion pulse
//   div_zero    : completed operation had denom=0
//   signed_mode : (DLL_SEQ_DIVIDER_SIGNED_EN only) two's complement operands
// ---------------------------------------------------------------------------
module dll_seq_divider
    import dll_div_pkg::*;
#(
    parameter int NUM_WIDTH      = 9,
    parameter int DEN_WIDTH      = 9,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_WIDTH-1:0] numer,
    input  logic [DEN_WIDTH-1:0] denom,
    output logic                 ready,
    output logic [NUM_WIDTH-1:0] quotient,
    output logic [DEN_WIDTH-1:0] remain,
    output logic                 done,
    output logic                 div_zero
`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
    ,
    input  logic                 signed_mode
`endif
);

    localparam int ITER      = calc_iter(NUM_WIDTH, BITS_PER_CYCLE);
    localparam int PAD_WIDTH = ITER * BITS_PER_CYCLE;
    localparam int CNT_W     = cnt_width(ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Numerator shifts out at the top while quotient bits shift in at the
    // bottom; after ITER steps the low NUM_WIDTH bits are the quotient.
    logic [PAD_WIDTH-1:0] num_work_q, num_work_d;
    logic [DEN_WIDTH-1:0] rem_q, rem_d;
    logic [DEN_WIDTH-1:0] denom_q, denom_d;
    logic                 zero_q, zero_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [NUM_WIDTH-1:0] quotient_q, quotient_d;
    logic [DEN_WIDTH-1:0] remain_q, remain_d;
    logic                 div_zero_q, div_zero_d;
    logic                 done_q, done_d;

    logic                 signed_sel;
    logic [NUM_WIDTH-1:0] numer_mag;
    logic [DEN_WIDTH-1:0] denom_mag;
    logic                 denom_is_zero;

`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
    assign signed_sel = signed_mode;
`else
    assign signed_sel = 1'b0;
`endif

    assign numer_mag = (signed_sel && numer[NUM_WIDTH-1]) ? (NUM_WIDTH'(0) - numer) : numer;
    assign denom_mag = (signed_sel && denom[DEN_WIDTH-1]) ? (DEN_WIDTH'(0) - denom) : denom;
    assign denom_is_zero = (denom == '0);

    // Restoring step chain, MSB first within each iteration.
    logic [DEN_WIDTH-1:0]      rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            dll_div_step #(
                .DEN_WIDTH (DEN_WIDTH)
            ) u_step (
                .rem_i     (rem_chain[gi]),
                .num_bit_i (num_work_q[PAD_WIDTH-1-gi]),
                .denom_i   (denom_q),
                .rem_o     (rem_chain[gi+1]),
                .q_bit_o   (q_bits[BITS_PER_CYCLE-1-gi])
            );
        end
    endgenerate

    logic [PAD_WIDTH-1:0] num_shift;
    logic [NUM_WIDTH-1:0] q_mag;
    logic [DEN_WIDTH-1:0] r_mag;

    assign num_shift = (num_work_q << BITS_PER_CYCLE) | PAD_WIDTH'(q_bits);
    assign q_mag     = num_shift[NUM_WIDTH-1:0];
    assign r_mag     = rem_chain[BITS_PER_CYCLE];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_work_d = num_work_q;
        rem_d      = rem_q;
        denom_d    = denom_q;
        zero_d     = zero_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        quotient_d = quotient_q;
        remain_d   = remain_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    rem_d   = '0;
                    denom_d = denom_mag;
                    zero_d  = denom_is_zero;
                    q_neg_d = signed_sel & (numer[NUM_WIDTH-1] ^ denom[DEN_WIDTH-1]);
                    r_neg_d = signed_sel & numer[NUM_WIDTH-1];
                    if (denom_is_zero) begin
                        // Raw numerator kept so the remainder is numer truncated.
                        cnt_d      = '0;
                        num_work_d = PAD_WIDTH'(numer);
                    end else begin
                        // Zero left-padding makes the first iteration cover
                        // only the leftover bits when the width does not divide.
                        cnt_d      = CNT_LOAD;
                        num_work_d = PAD_WIDTH'(numer_mag);
                    end
                end
            end

            RUN: begin
                rem_d      = r_mag;
                num_work_d = num_shift;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    div_zero_d = zero_q;
                    if (zero_q) begin
                        quotient_d = r_neg_q ? DIV_ONE[NUM_WIDTH-1:0] : DIV_ALL_ONES[NUM_WIDTH-1:0];
                        remain_d   = num_work_q[DEN_WIDTH-1:0];
                    end else begin
                        // Most-negative / -1 falls out naturally: the magnitude
                        // wraps to the most-negative pattern and is not negated.
                        quotient_d = q_neg_q ? (NUM_WIDTH'(0) - q_mag) : q_mag;
                        remain_d   = r_neg_q ? (DEN_WIDTH'(0) - r_mag) : r_mag;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            num_work_q <= '0;
            rem_q      <= '0;
            denom_q    <= '0;
            zero_q     <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            quotient_q <= DIV_ZERO[NUM_WIDTH-1:0];
            remain_q   <= DIV_ZERO[DEN_WIDTH-1:0];
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_work_q <= num_work_d;
            rem_q      <= rem_d;
            denom_q    <= denom_d;
            zero_q     <= zero_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            quotient_q <= quotient_d;
            remain_q   <= remain_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign quotient = quotient_q;
    assign remain   = remain_q;
    assign div_zero = div_zero_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dll_seq_divider.sv
// Bench for dll_seq_divider: three instances (1, 2 and 4 bits per cycle)
// share clock, reset and operands; each has its own start strobe.
module tb_dll_seq_divider;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic [8:0] numer = '0, denom = '0;
    logic       signed_mode = 1'b0;

    logic       ready1, ready2, ready4;
    logic [8:0] quot1, quot2, quot4;
    logic [8:0] rem1, rem2, rem4;
    logic       done1, done2, done4;
    logic       dz1, dz2, dz4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] q;
        logic [8:0] r;
        logic       dz;
        int         lat1;
        int         lat2;
        int         lat4;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    dll_seq_divider #(.NUM_WIDTH(9), .DEN_WIDTH(9), .BITS_PER_CYCLE(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .numer(numer), .denom(denom),
        .ready(ready1), .quotient(quot1), .remain(rem1), .done(done1), .div_zero(dz1)
`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
        , .signed_mode(signed_mode)
`endif
    );

    dll_seq_divider #(.NUM_WIDTH(9), .DEN_WIDTH(9), .BITS_PER_CYCLE(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .numer(numer), .denom(denom),
        .ready(ready2), .quotient(quot2), .remain(rem2), .done(done2), .div_zero(dz2)
`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
        , .signed_mode(signed_mode)
`endif
    );

    dll_seq_divider #(.NUM_WIDTH(9), .DEN_WIDTH(9), .BITS_PER_CYCLE(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .start(start4), .numer(numer), .denom(denom),
        .ready(ready4), .quotient(quot4), .remain(rem4), .done(done4), .div_zero(dz4)
`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
        , .signed_mode(signed_mode)
`endif
    );

    // ---------------- stimulus / observation helpers (no checking) ----------
    task automatic issue(input logic [8:0] n, input logic [8:0] d,
                         input logic s1, input logic s2, input logic s4);
        @(negedge clock);
        numer  = n;
        denom  = d;
        start1 = s1;
        start2 = s2;
        start4 = s4;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts edges after the accepting edge until done1; -1 on timeout.
    task automatic run_until_done(input logic [8:0] hold_q, input logic [8:0] hold_r,
                                  output int cyc, output int early_ready, output int drift);
        cyc = -1;
        early_ready = 0;
        drift = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock);
            #1;
            if (done1) begin
                cyc = k;
                break;
            end
            if (ready1) early_ready++;
            if (quot1 !== hold_q || rem1 !== hold_r) drift++;
        end
    endtask

    task automatic capture_all(output int c1, output int c2, output int c4,
                               output logic [8:0] q1, output logic [8:0] r1, output logic z1,
                               output logic [8:0] q2, output logic [8:0] r2, output logic z2,
                               output logic [8:0] q4, output logic [8:0] r4, output logic z4);
        c1 = -1; c2 = -1; c4 = -1;
        q1 = 'x; r1 = 'x; z1 = 'x; q2 = 'x; r2 = 'x; z2 = 'x; q4 = 'x; r4 = 'x; z4 = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (done1 && c1 < 0) begin c1 = k; q1 = quot1; r1 = rem1; z1 = dz1; end
            if (done2 && c2 < 0) begin c2 = k; q2 = quot2; r2 = rem2; z2 = dz2; end
            if (done4 && c4 < 0) begin c4 = k; q4 = quot4; r4 = rem4; z4 = dz4; end
            if (c1 > 0 && c2 > 0 && c4 > 0) break;
        end
    endtask

    // Pops one expectation and compares it against all three instances.
    task automatic check_all_three(input string tag);
        int c1, c2, c4;
        logic [8:0] q1, r1, q2, r2, q4, r4;
        logic z1, z2, z4;
        exp_t e;
        capture_all(c1, c2, c4, q1, r1, z1, q2, r2, z2, q4, r4, z4);
        e = sb.pop_front();
        checks += 12;
        if (c1 !== e.lat1) begin errors++; $display("FAIL %s lat1: got %0d expected %0d", tag, c1, e.lat1); end
        if (c2 !== e.lat2) begin errors++; $display("FAIL %s lat2: got %0d expected %0d", tag, c2, e.lat2); end
        if (c4 !== e.lat4) begin errors++; $display("FAIL %s lat4: got %0d expected %0d", tag, c4, e.lat4); end
        if (q1 !== e.q) begin errors++; $display("FAIL %s q1: got %0d expected %0d", tag, q1, e.q); end
        if (q2 !== e.q) begin errors++; $display("FAIL %s q2: got %0d expected %0d", tag, q2, e.q); end
        if (q4 !== e.q) begin errors++; $display("FAIL %s q4: got %0d expected %0d", tag, q4, e.q); end
        if (r1 !== e.r) begin errors++; $display("FAIL %s r1: got %0d expected %0d", tag, r1, e.r); end
        if (r2 !== e.r) begin errors++; $display("FAIL %s r2: got %0d expected %0d", tag, r2, e.r); end
        if (r4 !== e.r) begin errors++; $display("FAIL %s r4: got %0d expected %0d", tag, r4, e.r); end
        if (z1 !== e.dz) begin errors++; $display("FAIL %s dz1: got %b expected %b", tag, z1, e.dz); end
        if (z2 !== e.dz) begin errors++; $display("FAIL %s dz2: got %b expected %b", tag, z2, e.dz); end
        if (z4 !== e.dz) begin errors++; $display("FAIL %s dz4: got %b expected %b", tag, z4, e.dz); end
        $display("op %s: q=%0d r=%0d dz=%b lat=%0d/%0d/%0d", tag, q1, r1, z1, c1, c2, c4);
    endtask

    function automatic exp_t unsigned_model(input int n, input int d);
        exp_t e;
        if (d == 0) begin
            e.q = 9'h1FF; e.r = 9'(n); e.dz = 1'b1;
            e.lat1 = 1; e.lat2 = 1; e.lat4 = 1;
        end else begin
            e.q = 9'(n / d); e.r = 9'(n % d); e.dz = 1'b0;
            e.lat1 = 9; e.lat2 = 5; e.lat4 = 3;
        end
        return e;
    endfunction

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks += 5;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready1); end
        if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
        if (quot1 !== 9'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", quot1); end
        if (rem1 !== 9'd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", rem1); end
        if (dz1 !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", dz1); end
        @(negedge clock);
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        int cyc, early, drift;
        exp_t e;
        sb.push_back(unsigned_model(300, 7));
        issue(9'd300, 9'd7, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %b expected 0", ready1); end
        run_until_done(9'd0, 9'd0, cyc, early, drift);
        e = sb.pop_front();
        checks += 7;
        if (cyc !== e.lat1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, e.lat1); end
        if (early !== 0) begin errors++; $display("FAIL basic_ready_low: got %0d early cycles expected 0", early); end
        if (drift !== 0) begin errors++; $display("FAIL basic_hold: got %0d changed cycles expected 0", drift); end
        if (quot1 !== e.q) begin errors++; $display("FAIL basic_q: got %0d expected %0d", quot1, e.q); end
        if (rem1 !== e.r) begin errors++; $display("FAIL basic_r: got %0d expected %0d", rem1, e.r); end
        if (dz1 !== e.dz) begin errors++; $display("FAIL basic_dz: got %b expected %b", dz1, e.dz); end
        if (ready1 !== 1'b1) begin errors++; $display("FAIL basic_ready_done: got %b expected 1", ready1); end
        @(posedge clock);
        #1;
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done1); end
        $display("op 300/7: q=%0d r=%0d dz=%b lat=%0d", quot1, rem1, dz1, cyc);
    endtask

    task automatic test_div_zero();
        int cyc, early, drift;
        exp_t e;
        sb.push_back(unsigned_model(100, 0));
        issue(9'd100, 9'd0, 1'b1, 1'b0, 1'b0);
        run_until_done(9'd42, 9'd6, cyc, early, drift);
        e = sb.pop_front();
        checks += 4;
        if (cyc !== e.lat1) begin errors++; $display("FAIL dz_latency: got %0d expected %0d", cyc, e.lat1); end
        if (quot1 !== e.q) begin errors++; $display("FAIL dz_q: got %0d expected %0d", quot1, e.q); end
        if (rem1 !== e.r) begin errors++; $display("FAIL dz_r: got %0d expected %0d", rem1, e.r); end
        if (dz1 !== e.dz) begin errors++; $display("FAIL dz_flag: got %b expected %b", dz1, e.dz); end
        $display("op 100/0: q=%0d r=%0d dz=%b lat=%0d", quot1, rem1, dz1, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc, early, drift;
        exp_t e;
        // 300/7 with an ignored 50/5 request three edges into the run.
        sb.push_back(unsigned_model(300, 7));
        issue(9'd300, 9'd7, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        numer = 9'd50; denom = 9'd5; start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        run_until_done(9'd511, 9'd100, cyc, early, drift);
        e = sb.pop_front();
        checks += 4;
        if (cyc + 3 !== e.lat1) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", cyc + 3, e.lat1); end
        if (quot1 !== e.q) begin errors++; $display("FAIL ignore_q: got %0d expected %0d", quot1, e.q); end
        if (rem1 !== e.r) begin errors++; $display("FAIL ignore_r: got %0d expected %0d", rem1, e.r); end
        if (drift !== 0) begin errors++; $display("FAIL ignore_hold: got %0d changed cycles expected 0", drift); end
        $display("op 300/7 (start ignored): q=%0d r=%0d lat=%0d", quot1, rem1, cyc + 3);
        // Reissue inside the done cycle.
        sb.push_back(unsigned_model(50, 5));
        numer = 9'd50; denom = 9'd5; start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        checks += 2;
        if (ready1 !== 1'b0) begin errors++; $display("FAIL b2b_accept: got ready %b expected 0", ready1); end
        if (done1 !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", done1); end
        run_until_done(9'd42, 9'd6, cyc, early, drift);
        e = sb.pop_front();
        checks += 5;
        if (cyc !== e.lat1) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, e.lat1); end
        if (quot1 !== e.q) begin errors++; $display("FAIL b2b_q: got %0d expected %0d", quot1, e.q); end
        if (rem1 !== e.r) begin errors++; $display("FAIL b2b_r: got %0d expected %0d", rem1, e.r); end
        if (dz1 !== e.dz) begin errors++; $display("FAIL b2b_dz: got %b expected %b", dz1, e.dz); end
        if (drift !== 0) begin errors++; $display("FAIL b2b_hold: got %0d changed cycles expected 0", drift); end
        $display("op 50/5 (back-to-back): q=%0d r=%0d lat=%0d", quot1, rem1, cyc);
    endtask

    task automatic test_reset_mid_op();
        int cyc, early, drift, late_done;
        exp_t e;
        // Leave a nonzero result in place so the reset clearing is visible.
        sb.push_back(unsigned_model(100, 0));
        issue(9'd100, 9'd0, 1'b1, 1'b0, 1'b0);
        run_until_done(9'd10, 9'd0, cyc, early, drift);
        e = sb.pop_front();
        checks++;
        if (quot1 !== e.q) begin errors++; $display("FAIL pre_reset_q: got %0d expected %0d", quot1, e.q); end
        issue(9'd300, 9'd7, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready1); end
        if (done1 !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done1); end
        if (quot1 !== 9'd0) begin errors++; $display("FAIL abort_q: got %0d expected 0", quot1); end
        if (rem1 !== 9'd0) begin errors++; $display("FAIL abort_r: got %0d expected 0", rem1); end
        if (dz1 !== 1'b0) begin errors++; $display("FAIL abort_dz: got %b expected 0", dz1); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            #1;
            if (done1) late_done++;
        end
        checks++;
        if (late_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", late_done); end
        $display("abort: reset mid-op, done pulses after release=%0d", late_done);
        sb.push_back(unsigned_model(300, 7));
        issue(9'd300, 9'd7, 1'b1, 1'b0, 1'b0);
        run_until_done(9'd0, 9'd0, cyc, early, drift);
        e = sb.pop_front();
        checks += 3;
        if (cyc !== e.lat1) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", cyc, e.lat1); end
        if (quot1 !== e.q) begin errors++; $display("FAIL post_reset_q: got %0d expected %0d", quot1, e.q); end
        if (rem1 !== e.r) begin errors++; $display("FAIL post_reset_r: got %0d expected %0d", rem1, e.r); end
        $display("op 300/7 after reset: q=%0d r=%0d lat=%0d", quot1, rem1, cyc);
    endtask

    task automatic test_multi_bit();
        sb.push_back(unsigned_model(511, 3));
        issue(9'd511, 9'd3, 1'b1, 1'b1, 1'b1);
        check_all_three("511/3");
    endtask

    task automatic test_random();
        int n, d;
        for (int i = 0; i < 20; i++) begin
            n = int'($urandom_range(0, 511));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511));
            if (i == 0) d = 1;
            if (i == 1) begin n = 511; d = 511; end
            sb.push_back(unsigned_model(n, d));
            issue(9'(n), 9'(d), 1'b1, 1'b1, 1'b1);
            check_all_three($sformatf("%0d/%0d", n, d));
        end
    endtask

`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int ns [6] = '{-100, -256, 100, -5, 5, -255};
        int ds [6] = '{7, -1, -7, 0, 0, 16};
        exp_t e;
        signed_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ds[i] == 0) begin
                e.q = (ns[i] >= 0) ? 9'h1FF : 9'd1;
                e.r = 9'(ns[i]);
                e.dz = 1'b1;
                e.lat1 = 1; e.lat2 = 1; e.lat4 = 1;
            end else if (ns[i] == -256 && ds[i] == -1) begin
                e.q = 9'h100; e.r = 9'd0; e.dz = 1'b0;
                e.lat1 = 9; e.lat2 = 5; e.lat4 = 3;
            end else begin
                e.q = 9'(ns[i] / ds[i]); e.r = 9'(ns[i] % ds[i]); e.dz = 1'b0;
                e.lat1 = 9; e.lat2 = 5; e.lat4 = 3;
            end
            sb.push_back(e);
            issue(9'(ns[i]), 9'(ds[i]), 1'b1, 1'b1, 1'b1);
            check_all_three($sformatf("signed %0d/%0d", ns[i], ds[i]));
        end
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_multi_bit();
        test_random();
`ifdef DLL_SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
